// File: rtl/mlp_conv_pkg.sv
// Shared types and helpers for the mlp_conv datapath blocks.
package mlp_conv_pkg;

    typedef enum logic [1:0] {IDLE, FETCH, STREAM} unpack_state_t;

    function automatic int lanes(input int data_width, input int elem_width);
        return data_width / elem_width;
    endfunction

endpackage

// File: rtl/fifo_axis_unpacker.sv
// Pops words from a first-word-fall-through FIFO and serialises them lane by lane
// onto an AXI-Stream master, framing CFG_LEN elements with TLAST.
module fifo_axis_unpacker
    import mlp_conv_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ELEM_WIDTH = 8,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                  CLK,
    input  logic                  RESETN,
    input  logic                  CFG_START,
    input  logic [LEN_WIDTH-1:0]  CFG_LEN,
    output logic                  FIFO_RD_CMD,
    input  logic [DATA_WIDTH-1:0] FIFO_RD_DATA,
    input  logic                  FIFO_EMPTY,
    output logic [ELEM_WIDTH-1:0] M_AXIS_TDATA,
    output logic                  M_AXIS_TVALID,
    input  logic                  M_AXIS_TREADY,
    output logic                  M_AXIS_TLAST,
    output logic                  BUSY,
    output logic                  DONE
);

    localparam int LANES  = lanes(DATA_WIDTH, ELEM_WIDTH);
    localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);

    if (DATA_WIDTH % ELEM_WIDTH != 0) begin : g_width_check
        $error("fifo_axis_unpacker: DATA_WIDTH must be a multiple of ELEM_WIDTH");
    end

    unpack_state_t          state;
    unpack_state_t          next_state;
    logic [DATA_WIDTH-1:0]  word;
    logic [LANE_W-1:0]      lane;
    logic [LEN_WIDTH-1:0]   remaining;
    logic                   done;
    logic                   pop;
    logic                   last_elem;
    logic [ELEM_WIDTH-1:0]  elem;

    assign last_elem = (remaining == LEN_WIDTH'(1));

    always_comb begin
        next_state = state;
        pop        = 1'b0;
        elem       = '0;
        for (int i = 0; i < LANES; i++) begin
            if (lane == LANE_W'(i)) begin
                elem = word[i*ELEM_WIDTH +: ELEM_WIDTH];
            end
        end
        case (state)
            IDLE: begin
                if (CFG_START && (CFG_LEN != '0)) begin
                    next_state = FETCH;
                end
            end
            FETCH: begin
                if (!FIFO_EMPTY) begin
                    pop        = 1'b1;
                    next_state = STREAM;
                end
            end
            STREAM: begin
                if (M_AXIS_TREADY) begin
                    if (last_elem) begin
                        next_state = IDLE;
                    end else if (lane == LAST_LANE) begin
                        // Refill in the same cycle to keep the stream gap-free.
                        if (!FIFO_EMPTY) begin
                            pop = 1'b1;
                        end else begin
                            next_state = FETCH;
                        end
                    end
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state     <= IDLE;
            word      <= '0;
            lane      <= '0;
            remaining <= '0;
            done      <= 1'b0;
        end else begin
            state <= next_state;
            done  <= 1'b0;
            case (state)
                IDLE: begin
                    if (CFG_START) begin
                        remaining <= CFG_LEN;
                        done      <= (CFG_LEN == '0);
                    end
                end
                FETCH: begin
                    if (pop) begin
                        word <= FIFO_RD_DATA;
                        lane <= '0;
                    end
                end
                STREAM: begin
                    if (M_AXIS_TREADY) begin
                        if (remaining != '0) begin
                            remaining <= remaining - LEN_WIDTH'(1);
                        end
                        if (last_elem) begin
                            done <= 1'b1;
                        end else if (lane == LAST_LANE) begin
                            lane <= '0;
                            if (pop) begin
                                word <= FIFO_RD_DATA;
                            end
                        end else begin
                            lane <= lane + LANE_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign FIFO_RD_CMD   = pop;
    assign M_AXIS_TVALID = (state == STREAM);
    assign M_AXIS_TLAST  = (state == STREAM) && last_elem;
    assign M_AXIS_TDATA  = (state == STREAM) ? elem : '0;
    assign BUSY          = (state != IDLE);
    assign DONE          = done;

endmodule

// File: tb/tb_fifo_axis_unpacker.sv
// Directed bench for fifo_axis_unpacker: a small FWFT FIFO model feeds the DUT and a
// negedge monitor records accepted beats, pops and DONE pulses for the checks.
module tb_fifo_axis_unpacker;

    logic        CLK = 1'b0;
    logic        RESETN;
    logic        CFG_START;
    logic [15:0] CFG_LEN;
    logic        FIFO_RD_CMD;
    logic [31:0] FIFO_RD_DATA;
    logic        FIFO_EMPTY;
    logic [7:0]  M_AXIS_TDATA;
    logic        M_AXIS_TVALID;
    logic        M_AXIS_TREADY;
    logic        M_AXIS_TLAST;
    logic        BUSY;
    logic        DONE;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int start_cyc = 0;

    logic [31:0] fifo_mem [0:15];
    int          wr_ptr = 0;
    int          rd_ptr = 0;

    logic [7:0]  cap_data [0:15];
    logic        cap_last [0:15];
    int          cap_cyc  [0:15];
    int          n = 0;
    int          pops = 0;
    int          first_pop_cyc = -1;
    int          bad_pops = 0;
    int          dones = 0;
    int          done_cyc = -1;
    int          stab_err = 0;
    logic        prev_valid = 1'b0;
    logic        prev_ready = 1'b0;
    logic [7:0]  prev_data = '0;
    logic        prev_last = 1'b0;

    fifo_axis_unpacker #(.DATA_WIDTH(32), .ELEM_WIDTH(8), .LEN_WIDTH(16)) dut (
        .CLK(CLK), .RESETN(RESETN), .CFG_START(CFG_START), .CFG_LEN(CFG_LEN),
        .FIFO_RD_CMD(FIFO_RD_CMD), .FIFO_RD_DATA(FIFO_RD_DATA), .FIFO_EMPTY(FIFO_EMPTY),
        .M_AXIS_TDATA(M_AXIS_TDATA), .M_AXIS_TVALID(M_AXIS_TVALID),
        .M_AXIS_TREADY(M_AXIS_TREADY), .M_AXIS_TLAST(M_AXIS_TLAST),
        .BUSY(BUSY), .DONE(DONE)
    );

    always #5 CLK = ~CLK;

    assign FIFO_EMPTY   = (wr_ptr == rd_ptr);
    assign FIFO_RD_DATA = fifo_mem[rd_ptr[3:0]];

    always @(posedge CLK) begin
        cyc <= cyc + 1;
        if (FIFO_RD_CMD && !FIFO_EMPTY) rd_ptr <= rd_ptr + 1;
    end

    // Inputs only change just after posedge, so negedge values are what the next edge sees.
    always @(negedge CLK) begin
        if (!RESETN) begin
            prev_valid = 1'b0;
        end else begin
            if (prev_valid && !prev_ready) begin
                if (!(M_AXIS_TVALID && M_AXIS_TDATA == prev_data && M_AXIS_TLAST == prev_last))
                    stab_err++;
            end
            if (M_AXIS_TVALID && M_AXIS_TREADY && n < 16) begin
                cap_data[n] = M_AXIS_TDATA;
                cap_last[n] = M_AXIS_TLAST;
                cap_cyc[n]  = cyc;
                n++;
            end
            if (FIFO_RD_CMD) begin
                if (pops == 0) first_pop_cyc = cyc;
                pops++;
                if (FIFO_EMPTY) bad_pops++;
            end
            if (DONE) begin
                dones++;
                done_cyc = cyc;
            end
            prev_valid = M_AXIS_TVALID;
            prev_ready = M_AXIS_TREADY;
            prev_data  = M_AXIS_TDATA;
            prev_last  = M_AXIS_TLAST;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic push_word(input logic [31:0] w);
        fifo_mem[wr_ptr[3:0]] = w;
        wr_ptr++;
    endtask

    task automatic clear_capture();
        n = 0; pops = 0; first_pop_cyc = -1; bad_pops = 0;
        dones = 0; done_cyc = -1; stab_err = 0;
    endtask

    task automatic applyStimulus(input logic [15:0] len);
        @(posedge CLK); #1;
        CFG_START = 1'b1;
        CFG_LEN   = len;
        start_cyc = cyc;
        @(posedge CLK); #1;
        CFG_START = 1'b0;
    endtask

    // mode 0: TREADY=1; 1: alternate starting low; 2: late second word; 3: stray CFG_START
    task automatic run_until_done(input string tag, input int budget, input int mode);
        for (int i = 0; i < budget; i++) begin
            @(posedge CLK); #1;
            if (mode == 1) M_AXIS_TREADY = ((cyc - start_cyc) % 2 == 1);
            if (mode == 2 && cyc == start_cyc + 8) push_word(32'h88776655);
            if (mode == 3 && cyc == start_cyc + 4) begin CFG_START = 1'b1; CFG_LEN = 16'd2; end
            if (mode == 3 && cyc == start_cyc + 5) CFG_START = 1'b0;
            if (dones > 0) break;
        end
        M_AXIS_TREADY = 1'b1;
        CFG_START = 1'b0;
        checkOutput({tag, "_done_seen"}, 32'(dones > 0), 32'd1);
        repeat (3) @(posedge CLK);
        #1;
    endtask

    task automatic check_stream(input string tag, input int count, input int base);
        checkOutput({tag, "_count"}, n, count);
        for (int i = 0; i < count; i++) begin
            checkOutput($sformatf("%s_data%0d", tag, i), 32'(cap_data[i]), 32'(8'h11 * (base + i)));
            checkOutput($sformatf("%s_last%0d", tag, i), 32'(cap_last[i]), 32'(i == count - 1));
        end
    endtask

    initial begin
        RESETN = 1'b0; CFG_START = 1'b0; CFG_LEN = '0; M_AXIS_TREADY = 1'b0;
        #12;
        checkOutput("rst_tvalid", 32'(M_AXIS_TVALID), 32'd0);
        checkOutput("rst_tlast", 32'(M_AXIS_TLAST), 32'd0);
        checkOutput("rst_tdata", 32'(M_AXIS_TDATA), 32'd0);
        checkOutput("rst_busy", 32'(BUSY), 32'd0);
        checkOutput("rst_done", 32'(DONE), 32'd0);
        checkOutput("rst_rdcmd", 32'(FIFO_RD_CMD), 32'd0);
        @(posedge CLK); #3;
        RESETN = 1'b1;
        M_AXIS_TREADY = 1'b1;

        $display("[TB] full packet, LEN=8");
        clear_capture();
        push_word(32'h44332211); push_word(32'h88776655);
        applyStimulus(16'd8);
        checkOutput("t1_busy", 32'(BUSY), 32'd1);
        run_until_done("t1", 40, 0);
        check_stream("t1", 8, 1);
        checkOutput("t1_first_pop", first_pop_cyc, start_cyc + 1);
        checkOutput("t1_first_beat", cap_cyc[0], start_cyc + 2);
        checkOutput("t1_last_beat", cap_cyc[7], start_cyc + 9);
        checkOutput("t1_pops", pops, 2);
        checkOutput("t1_dones", dones, 1);
        checkOutput("t1_done_cyc", done_cyc, start_cyc + 10);
        checkOutput("t1_busy_after", 32'(BUSY), 32'd0);

        $display("[TB] partial word, LEN=6");
        clear_capture();
        push_word(32'h44332211); push_word(32'h88776655);
        applyStimulus(16'd6);
        run_until_done("t2", 40, 0);
        check_stream("t2", 6, 1);
        checkOutput("t2_pops", pops, 2);
        checkOutput("t2_empty", 32'(FIFO_EMPTY), 32'd1);
        checkOutput("t2_done_cyc", done_cyc, start_cyc + 8);

        $display("[TB] backpressure, LEN=8");
        clear_capture();
        push_word(32'h44332211); push_word(32'h88776655);
        applyStimulus(16'd8);
        run_until_done("t3", 60, 1);
        check_stream("t3", 8, 1);
        checkOutput("t3_stable", stab_err, 0);
        checkOutput("t3_pops", pops, 2);
        checkOutput("t3_first_beat", cap_cyc[0], start_cyc + 3);
        checkOutput("t3_last_beat", cap_cyc[7], start_cyc + 17);

        $display("[TB] underflow gap");
        clear_capture();
        push_word(32'h44332211);
        applyStimulus(16'd8);
        run_until_done("t4", 60, 2);
        check_stream("t4", 8, 1);
        checkOutput("t4_beat3", cap_cyc[3], start_cyc + 5);
        checkOutput("t4_beat4", cap_cyc[4], start_cyc + 9);
        checkOutput("t4_bad_pops", bad_pops, 0);
        checkOutput("t4_pops", pops, 2);
        checkOutput("t4_done_cyc", done_cyc, start_cyc + 13);

        $display("[TB] zero length packet");
        clear_capture();
        applyStimulus(16'd0);
        checkOutput("t5_busy", 32'(BUSY), 32'd0);
        run_until_done("t5", 20, 0);
        checkOutput("t5_done_cyc", done_cyc, start_cyc + 1);
        checkOutput("t5_dones", dones, 1);
        checkOutput("t5_beats", n, 0);
        checkOutput("t5_pops", pops, 0);

        $display("[TB] stray CFG_START mid-packet");
        clear_capture();
        push_word(32'h44332211); push_word(32'h88776655);
        applyStimulus(16'd8);
        run_until_done("t6", 40, 3);
        check_stream("t6", 8, 1);
        checkOutput("t6_dones", dones, 1);
        checkOutput("t6_done_cyc", done_cyc, start_cyc + 10);

        $display("[TB] reset mid-packet");
        clear_capture();
        push_word(32'h44332211); push_word(32'h88776655); push_word(32'hccbbaa99);
        applyStimulus(16'd8);
        repeat (4) @(posedge CLK);
        #1;
        checkOutput("t7_pre_rdcmd", 32'(FIFO_RD_CMD), 32'd1);
        checkOutput("t7_pre_tdata", 32'(M_AXIS_TDATA), 32'h44);
        #2;
        RESETN = 1'b0;
        #1;
        checkOutput("t7_rst_tvalid", 32'(M_AXIS_TVALID), 32'd0);
        checkOutput("t7_rst_busy", 32'(BUSY), 32'd0);
        checkOutput("t7_rst_rdcmd", 32'(FIFO_RD_CMD), 32'd0);
        checkOutput("t7_rst_tdata", 32'(M_AXIS_TDATA), 32'd0);
        @(posedge CLK); #3;
        RESETN = 1'b1;
        checkOutput("t7_beats_before", n, 3);
        checkOutput("t7_pops_before", pops, 1);
        clear_capture();
        applyStimulus(16'd4);
        run_until_done("t7", 40, 0);
        check_stream("t7", 4, 5);
        checkOutput("t7_pops", pops, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
